// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-type constants, default widths.
// Latency: n/a (package). Backpressure: n/a.
// Used by both the transmit serializer and the oversampled receive path.
package uart_pkg;

    localparam int UART_DATA_WIDTH     = 8;
    localparam int UART_PRESCALE_WIDTH = 6;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of a data word, even or odd; shared with the Rx parity checker.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Even parity makes the total count of ones even; odd parity makes it odd.
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    always_comb begin
        par_bit = (par_typ == PAR_ODD) ? ~(^data) : (^data);
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional parity, stop (two if UART_TX_STOP2_EN).
// Latency: TX_OUT falls on the edge that accepts Data_Valid; each bit lasts max(Prescale,1) cycles.
// Backpressure: Busy high from acceptance to end of stop; Data_Valid while Busy is dropped.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [2:0]                state;
    logic [PRESCALE_WIDTH-1:0] bit_cnt;
    logic [PRESCALE_WIDTH-1:0] pb_q;
    logic [IDX_W-1:0]          bit_idx;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic [DATA_WIDTH-1:0]     shift_nxt;
    logic                      par_en_q;
    logic                      par_bit_q;
    logic                      par_calc;
    logic                      bit_done;
`ifdef UART_TX_STOP2_EN
    logic                      stop_idx;
`endif

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_calc)
    );

    assign bit_done  = (bit_cnt == pb_q - PRESCALE_WIDTH'(1));
    assign shift_nxt = shift_q >> 1;

    // TX_OUT is driven from the next state so the line is a clean flop output.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            pb_q      <= PRESCALE_WIDTH'(1);
            bit_idx   <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop_idx  <= 1'b0;
`endif
        end else begin
            if (state != ST_IDLE) begin
                bit_cnt <= bit_done ? '0 : bit_cnt + PRESCALE_WIDTH'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (Data_Valid) begin
                        state     <= ST_START;
                        shift_q   <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_bit_q <= par_calc;
                        pb_q      <= (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
                        bit_cnt   <= '0;
                        bit_idx   <= '0;
                        TX_OUT    <= 1'b0;
                        Busy      <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        state  <= ST_DATA;
                        TX_OUT <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        shift_q <= shift_nxt;
                        if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                            bit_idx <= '0;
                            if (par_en_q) begin
                                state  <= ST_PARITY;
                                TX_OUT <= par_bit_q;
                            end else begin
                                state  <= ST_STOP;
                                TX_OUT <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            TX_OUT  <= shift_nxt[0];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        state  <= ST_STOP;
                        TX_OUT <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
`ifdef UART_TX_STOP2_EN
                        if (!stop_idx) begin
                            stop_idx <= 1'b1;
                        end else begin
                            stop_idx <= 1'b0;
                            state    <= ST_IDLE;
                            Busy     <= 1'b0;
                        end
`else
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
`endif
                        TX_OUT <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: directed frames plus randomized frames
// compared cycle by cycle against a frame-level reference model.
module tb_uart_tx_serializer;

    localparam int DW    = 8;
    localparam int LIMIT = 1200;
`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    int   checks = 0;
    int   errors = 0;
    logic tx_log   [0:LIMIT-1];
    logic busy_log [0:LIMIT-1];
    int   n_samp;
    int   busy_cnt;

    uart_tx_serializer dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic int model_nbits(input bit pen);
        return 1 + DW + int'(pen) + NSTOP;
    endfunction

    // Expected line level during bit k of a frame.
    function automatic logic model_bit(input logic [7:0] d, input bit pen, input bit ptyp, input int k);
        int ones;
        ones = $countones(d);
        if (k == 0) return 1'b0;
        if (k <= DW) return d[k-1];
        if (k == DW + 1 && pen) return ptyp ? logic'((ones + 1) % 2) : logic'(ones % 2);
        return 1'b1;
    endfunction

    // Number of captured samples disagreeing with the model frame, including the idle sample after it.
    function automatic int frame_errs(input logic [7:0] d, input bit pen, input bit ptyp, input int presc);
        int pb, nb, e;
        pb = (presc == 0) ? 1 : presc;
        nb = model_nbits(pen);
        e  = 0;
        if (n_samp != nb * pb + 1) e++;
        for (int i = 0; i < nb * pb && i < n_samp; i++) begin
            if (tx_log[i] !== model_bit(d, pen, ptyp, i / pb)) e++;
            if (busy_log[i] !== 1'b1) e++;
        end
        if (n_samp == nb * pb + 1) begin
            if (tx_log[nb*pb] !== 1'b1) e++;
            if (busy_log[nb*pb] !== 1'b0) e++;
        end
        return e;
    endfunction

    // Samples the line once per cycle on the falling edge until Busy drops.
    task automatic capture(input bit drop_dv);
        n_samp   = 0;
        busy_cnt = 0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge CLK);
            tx_log[i]   = TX_OUT;
            busy_log[i] = Busy;
            n_samp      = i + 1;
            if (Busy) busy_cnt++;
            if (drop_dv) Data_Valid = 1'b0;
            if (!Busy) break;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; Data_Valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
        repeat (3) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", TX_OUT); end
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle got tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy); end
    endtask

    task automatic test_basic_a5();
        logic [0:9] exp_seq;
        logic [0:9] got_seq;
        int e;
        exp_seq = 10'b0101001011;
        P_DATA = 8'hA5; PAR_EN = 1'b0; Prescale = 6'd8; Data_Valid = 1'b1;
        capture(1);
        for (int k = 0; k < 10; k++) got_seq[k] = tx_log[k*8+4];
        checks++;
        if (got_seq !== exp_seq) begin errors++; $display("FAIL a5_bits got %b want %b", got_seq, exp_seq); end
        checks++;
        if (busy_cnt !== (1 + DW + NSTOP) * 8)
            begin errors++; $display("FAIL a5_busy got %0d want %0d", busy_cnt, (1 + DW + NSTOP) * 8); end
        e = frame_errs(8'hA5, 1'b0, 1'b0, 8);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL a5_frame got %0d bad samples want 0", e); end
    endtask

    task automatic test_parity();
        logic [7:0] dat  [3];
        logic       typ  [3];
        logic       epar [3];
        int e;
        dat  = '{8'hA5, 8'hA5, 8'h01};
        typ  = '{1'b0, 1'b1, 1'b0};
        epar = '{1'b0, 1'b1, 1'b1};
        for (int t = 0; t < 3; t++) begin
            P_DATA = dat[t]; PAR_EN = 1'b1; PAR_TYP = typ[t]; Prescale = 6'd16; Data_Valid = 1'b1;
            capture(1);
            checks++;
            if (tx_log[9*16+8] !== epar[t])
                begin errors++; $display("FAIL parity_bit case %0d got %b want %b", t, tx_log[9*16+8], epar[t]); end
            checks++;
            if (busy_cnt !== (2 + DW + NSTOP) * 16)
                begin errors++; $display("FAIL parity_busy case %0d got %0d want %0d", t, busy_cnt, (2 + DW + NSTOP) * 16); end
            e = frame_errs(dat[t], 1'b1, typ[t], 16);
            checks++;
            if (e !== 0) begin errors++; $display("FAIL parity_frame case %0d got %0d bad samples want 0", t, e); end
        end
    endtask

    task automatic test_back_to_back();
        int e;
        int extra;
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd4; Data_Valid = 1'b1;
        @(posedge CLK);
        #1 P_DATA = 8'hC3;
        capture(0);
        e = frame_errs(8'h3C, 1'b0, 1'b0, 4);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL b2b_first got %0d bad samples want 0", e); end
        capture(1);
        e = frame_errs(8'hC3, 1'b0, 1'b0, 4);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL b2b_second got %0d bad samples want 0", e); end
        extra = 0;
        repeat (6) begin
            @(negedge CLK);
            if (Busy !== 1'b0 || TX_OUT !== 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL b2b_no_third got %0d busy cycles want 0", extra); end
    endtask

    task automatic test_midframe_change();
        logic [7:0] d1, d2;
        bit pt;
        int e;
        d1 = 8'($urandom); d2 = 8'($urandom); pt = 1'($urandom);
        P_DATA = d1; PAR_EN = 1'b0; PAR_TYP = pt; Prescale = 6'd8; Data_Valid = 1'b1;
        fork
            capture(1);
            begin
                repeat (20) @(negedge CLK);
                Prescale = 6'd4;
                PAR_EN   = 1'b1;
            end
        join
        e = frame_errs(d1, 1'b0, pt, 8);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL midframe_first got %0d bad samples want 0", e); end
        P_DATA = d2; Data_Valid = 1'b1;
        capture(1);
        e = frame_errs(d2, 1'b1, pt, 4);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL midframe_next got %0d bad samples want 0", e); end
    endtask

    task automatic test_prescale_zero();
        int e;
        P_DATA = 8'hFF; PAR_EN = 1'b0; Prescale = 6'd0; Data_Valid = 1'b1;
        capture(1);
        checks++;
        if (busy_cnt !== 1 + DW + NSTOP)
            begin errors++; $display("FAIL presc0_busy got %0d want %0d", busy_cnt, 1 + DW + NSTOP); end
        e = frame_errs(8'hFF, 1'b0, 1'b0, 0);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL presc0_frame got %0d bad samples want 0", e); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int e;
        d = 8'($urandom) & 8'hF7;
        P_DATA = d; PAR_EN = 1'b0; Prescale = 6'd8; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (34) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b0 || Busy !== 1'b1)
            begin errors++; $display("FAIL rst_mid_pre got tx=%b busy=%b want tx=0 busy=1", TX_OUT, Busy); end
        #2 RST = 1'b1;
        #1;
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0)
            begin errors++; $display("FAIL rst_mid_async got tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy); end
        @(negedge CLK);
        RST = 1'b0;
        d = 8'($urandom);
        P_DATA = d; PAR_EN = 1'b1; PAR_TYP = 1'b1; Prescale = 6'd3; Data_Valid = 1'b1;
        capture(1);
        e = frame_errs(d, 1'b1, 1'b1, 3);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL rst_mid_after got %0d bad samples want 0", e); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit pen, pt;
        int presc, e;
        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom); pen = 1'($urandom); pt = 1'($urandom);
            presc = $urandom_range(0, 12);
            P_DATA = d; PAR_EN = pen; PAR_TYP = pt; Prescale = 6'(presc); Data_Valid = 1'b1;
            capture(1);
            e = frame_errs(d, pen, pt, presc);
            checks++;
            if (e !== 0)
                begin errors++; $display("FAIL random_frame %0d d=%h pen=%0d typ=%0d presc=%0d got %0d bad samples want 0",
                                         n, d, pen, pt, presc, e); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_a5();
        test_parity();
        test_back_to_back();
        test_midframe_change();
        test_prescale_zero();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit serializer; the transmit-side counterpart of the oversampled receive path in the UART system.
- Accepts one parallel byte per handshake and emits a frame on TX_OUT, LSB first: start bit, data bits, optional parity bit, stop bit.
- Runs on the same oversampling clock as the receiver. Each serial bit is held for Prescale clock cycles, so one Prescale setting serves both directions.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of Prescale and of the internal bit-period counter.

Ports:
- CLK  input  1  system/oversampling clock, rising-edge.
- RST  input  1  reset, asynchronous, active-high.
- P_DATA  input  DATA_WIDTH  parallel byte to send.
- Data_Valid  input  1  request to send P_DATA; honoured only when Busy=0.
- PAR_EN  input  1  1 = insert parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- Prescale  input  PRESCALE_WIDTH  clock cycles per serial bit.
- TX_OUT  output  1  serial line, idle high, registered.
- Busy  output  1  high from frame acceptance until the end of the stop bit(s), registered.

Behaviour:
- Reset (asynchronous, active-high): TX_OUT=1, Busy=0, FSM=IDLE, bit-period and bit-index counters cleared, shift register cleared. Reset mid-frame aborts the frame immediately; the line returns high with no glitch low.
- FSM states:
  - IDLE: TX_OUT=1.
  - START: TX_OUT=0.
  - DATA: TX_OUT=shift[0].
  - PARITY: TX_OUT=parity bit.
  - STOP: TX_OUT=1.
- Acceptance: on a CLK edge with FSM=IDLE and Data_Valid=1, latch P_DATA, PAR_EN, PAR_TYP and Prescale; compute parity; go to START. TX_OUT falls and Busy rises on that same edge. Latency Data_Valid->start bit is one cycle.
- Data_Valid while Busy=1 is ignored (no queueing, no error flag).
- Latched Prescale value 0 is treated as 1. Bit period Pb = max(Prescale,1). Later changes to the Prescale, PAR_EN or PAR_TYP inputs do not affect a frame in flight.
- Bit timing: a counter counts 0..Pb-1 per bit. At terminal count the FSM advances to the next bit and the counter wraps to 0.
- DATA state: holds for DATA_WIDTH bit periods; the shift register shifts right at each bit boundary; the bit index counts 0..DATA_WIDTH-1.
- Transitions:
  - START -> DATA.
  - DATA (last bit) -> PARITY if PAR_EN latched, else STOP.
  - PARITY -> STOP.
  - STOP (terminal count) -> IDLE, Busy=0.
- Parity: even = XOR-reduce(data); odd = ~XOR-reduce(data).
- Frame length: (1 + DATA_WIDTH + PAR_EN + 1)·Pb cycles of Busy=1.
- Back-to-back: the earliest next acceptance is the edge after IDLE is re-entered. The minimum line idle between frames is one CLK cycle.

Optional Feature:
- Macro: UART_TX_STOP2_EN.
- Defined: STOP lasts two bit periods (2·Pb cycles) before IDLE; the frame-length formula gains +1 bit.
- Undefined: a single stop bit, as specified above.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding localparams/typedef (IDLE, START, DATA, PARITY, STOP), shared encoding style with the Rx FSM.
  - Parity-type constants PAR_EVEN=0 and PAR_ODD=1.
  - Default DATA_WIDTH and PRESCALE_WIDTH.
- One natural sub-module: uart_tx_parity_calc, a combinational parity from data and type. It is reusable by the Rx parity checker.
- FSM, counters and shifter stay in uart_tx_serializer.

Test Plan:
- Prescale=8, PAR_EN=0, P_DATA=0xA5, Data_Valid pulse -> TX_OUT bit sequence 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; Busy high exactly 80 cycles; TX_OUT=1 afterward.
- Prescale=16, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5 -> parity bit 0, 11 bits, Busy 176 cycles. Repeat with PAR_TYP=1 -> parity bit 1. P_DATA=0x01 even -> parity bit 1.
- Data_Valid held high continuously with P_DATA=0x3C then 0xC3 -> exactly one frame per acceptance; at least 1 idle-high cycle between frames; the second frame carries the P_DATA value present on the acceptance edge.
- Mid-frame Prescale 8->4 and PAR_EN toggled during DATA -> current frame keeps 8 cycles/bit and original parity setting; the next frame uses 4.
- Prescale=0, P_DATA=0xFF, no parity -> 1 cycle/bit, 10-cycle frame.
- RST asserted during DATA bit 3 -> TX_OUT=1 and Busy=0 immediately (before the next edge). After release, a new Data_Valid starts a clean frame.
- (With UART_TX_STOP2_EN) Prescale=8, no parity -> stop high for 16 cycles; Busy 88 cycles.
